// File: rtl/registers.sv
// 32 x 32 MIPS general-purpose register file: two decode read ports with
// write-through bypass, one write-back write port, and a debug read port.
module registers #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs_sel,
  input  logic [ADDR_W-1:0] i_rt_sel,
  input  logic [ADDR_W-1:0] i_rd_sel,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_dbg_sel,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_live;

  // A write is only real when out of reset and not aimed at the zero register.
  assign wr_live = i_rst && i_wr_en && (i_rd_sel != '0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[i_rd_sel] <= i_wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] sel,
    input logic              bypass_ok
  );
    logic [DATA_W-1:0] val;
    val = regs[sel];
    if (sel == '0) begin
      val = '0;
    end else if (bypass_ok && wr_live && (sel == i_rd_sel)) begin
      val = i_wr_data;
    end
    return val;
  endfunction

  // Decode ports forward same-cycle write-back data; debug sees storage only.
  always_comb begin
    o_rs_data  = read_port(i_rs_sel, 1'b1);
    o_rt_data  = read_port(i_rt_sel, 1'b1);
    o_dbg_data = read_port(i_dbg_sel, 1'b0);
  end

endmodule

// File: tb/tb_registers.sv
// Directed self-checking bench for the registers file: reset, zero register,
// readback, bypass, write-enable gating, async reset mid-run.
module tb_registers;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              i_clk;
  logic              i_rst;
  logic [ADDR_W-1:0] i_rs_sel;
  logic [ADDR_W-1:0] i_rt_sel;
  logic [ADDR_W-1:0] i_rd_sel;
  logic              i_wr_en;
  logic [DATA_W-1:0] i_wr_data;
  logic [ADDR_W-1:0] i_dbg_sel;
  logic [DATA_W-1:0] o_rs_data;
  logic [DATA_W-1:0] o_rt_data;
  logic [DATA_W-1:0] o_dbg_data;

  int n_checks;
  int n_errors;

  registers #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rs_sel   (i_rs_sel),
    .i_rt_sel   (i_rt_sel),
    .i_rd_sel   (i_rd_sel),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .i_dbg_sel  (i_dbg_sel),
    .o_rs_data  (o_rs_data),
    .o_rt_data  (o_rt_data),
    .o_dbg_data (o_dbg_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write one register: inputs set on the falling edge, latched on the next rising edge.
  task automatic do_write(input logic [ADDR_W-1:0] sel, input logic [DATA_W-1:0] data);
    @(negedge i_clk);
    i_rd_sel  = sel;
    i_wr_data = data;
    i_wr_en   = 1'b1;
    @(posedge i_clk);
    #1;
    i_wr_en   = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    i_rst     = 1'b0;
    i_rs_sel  = '0;
    i_rt_sel  = '0;
    i_rd_sel  = '0;
    i_wr_en   = 1'b0;
    i_wr_data = '0;
    i_dbg_sel = '0;

    // Writes ignored and outputs zero while reset is held
    @(negedge i_clk);
    i_rd_sel  = 5'd5;
    i_wr_data = 32'hDEADBEEF;
    i_wr_en   = 1'b1;
    i_rs_sel  = 5'd5;
    i_rt_sel  = 5'd5;
    i_dbg_sel = 5'd5;
    #1;
    check("rst_bypass_rs", o_rs_data, 32'h0);
    check("rst_bypass_rt", o_rt_data, 32'h0);
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_rs_r5", o_rs_data, 32'h0);
    check("rst_dbg_r5", o_dbg_data, 32'h0);
    @(negedge i_clk);
    i_wr_en = 1'b0;
    i_rst   = 1'b1;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      i_dbg_sel = i[ADDR_W-1:0];
      #1;
      check($sformatf("rst_dbg_r%0d", i), o_dbg_data, 32'h0);
    end

    // Zero register ignores writes, even pre-edge
    @(negedge i_clk);
    i_rs_sel  = 5'd0;
    i_rt_sel  = 5'd0;
    i_dbg_sel = 5'd0;
    i_rd_sel  = 5'd0;
    i_wr_data = 32'hFFFFFFFF;
    i_wr_en   = 1'b1;
    #1;
    check("r0_pre_rs", o_rs_data, 32'h0);
    @(posedge i_clk);
    #1;
    i_wr_en = 1'b0;
    #1;
    check("r0_rs", o_rs_data, 32'h0);
    check("r0_rt", o_rt_data, 32'h0);
    check("r0_dbg", o_dbg_data, 32'h0);

    // Write and read back
    do_write(5'd1, 32'hFFFFFFFF);
    i_rs_sel = 5'd1;
    #1;
    check("wr_r1_ones", o_rs_data, 32'hFFFFFFFF);

    // Two registers on two ports, then same select on both
    do_write(5'd1, 32'h0123ABCD);
    do_write(5'd2, 32'h4567EF01);
    i_rs_sel = 5'd1;
    i_rt_sel = 5'd2;
    #1;
    check("dual_rs_r1", o_rs_data, 32'h0123ABCD);
    check("dual_rt_r2", o_rt_data, 32'h4567EF01);
    i_rs_sel = 5'd2;
    #1;
    check("same_rs_r2", o_rs_data, 32'h4567EF01);
    check("same_rt_r2", o_rt_data, 32'h4567EF01);

    // Bypass: decode ports forward pending write, debug does not
    @(negedge i_clk);
    i_rs_sel  = 5'd7;
    i_rt_sel  = 5'd7;
    i_dbg_sel = 5'd7;
    i_rd_sel  = 5'd7;
    i_wr_data = 32'h00001234;
    i_wr_en   = 1'b1;
    #1;
    check("byp_rs_pre", o_rs_data, 32'h00001234);
    check("byp_rt_pre", o_rt_data, 32'h00001234);
    check("byp_dbg_pre", o_dbg_data, 32'h0);
    @(posedge i_clk);
    #1;
    i_wr_en = 1'b0;
    #1;
    check("byp_dbg_post", o_dbg_data, 32'h00001234);
    // No forwarding when write enable is low
    i_wr_data = 32'h99999999;
    #1;
    check("nobyp_rs", o_rs_data, 32'h00001234);

    // Write-enable gating
    @(negedge i_clk);
    i_rd_sel  = 5'd3;
    i_wr_data = 32'hAAAA5555;
    i_wr_en   = 1'b0;
    i_dbg_sel = 5'd3;
    @(posedge i_clk);
    #1;
    check("wren_off_r3", o_dbg_data, 32'h0);

    // Top register and back-to-back last-write-wins
    do_write(5'd31, 32'h31313131);
    i_dbg_sel = 5'd31;
    #1;
    check("r31", o_dbg_data, 32'h31313131);
    @(negedge i_clk);
    i_rd_sel  = 5'd4;
    i_wr_data = 32'h00000011;
    i_wr_en   = 1'b1;
    @(negedge i_clk);
    i_wr_data = 32'h00000022;
    @(negedge i_clk);
    i_wr_en   = 1'b0;
    i_dbg_sel = 5'd4;
    #1;
    check("b2b_r4", o_dbg_data, 32'h00000022);

    // Async reset pulse between clock edges clears everything at once
    i_rs_sel  = 5'd1;
    i_rt_sel  = 5'd2;
    i_dbg_sel = 5'd31;
    #1;
    check("pre_rst_r1", o_rs_data, 32'h0123ABCD);
    i_rst = 1'b0;
    #1;
    check("arst_r1", o_rs_data, 32'h0);
    check("arst_r2", o_rt_data, 32'h0);
    check("arst_r31", o_dbg_data, 32'h0);
    i_dbg_sel = 5'd7;
    #1;
    check("arst_r7", o_dbg_data, 32'h0);
    i_rst = 1'b1;
    #1;
    check("arst_rel_r7", o_dbg_data, 32'h0);

    // Writes work again after release
    do_write(5'd9, 32'h5A5A0009);
    i_dbg_sel = 5'd9;
    #1;
    check("post_rst_r9", o_dbg_data, 32'h5A5A0009);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/registers.md
Name: registers

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS datapath.
- Sits between the decode stage (two read ports, rs/rt) and the write-back stage (one write port, rd).
- Register 0 is hardwired to zero.
- A third read-only port exposes any register to the debug unit.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register select width; depth is 2**ADDR_W = 32 entries.

Ports:
- i_clk  input  1  system clock; all writes occur on its rising edge.
- i_rst  input  1  asynchronous, active-low reset; clears every register.
- i_rs_sel  input  ADDR_W  source register select for read port A.
- i_rt_sel  input  ADDR_W  target register select for read port B.
- i_rd_sel  input  ADDR_W  destination register select for the write port.
- i_wr_en  input  1  write enable, active-high.
- i_wr_data  input  DATA_W  data to write.
- i_dbg_sel  input  ADDR_W  debug read select.
- o_rs_data  output  DATA_W  contents of register i_rs_sel.
- o_rt_data  output  DATA_W  contents of register i_rt_sel.
- o_dbg_data  output  DATA_W  contents of register i_dbg_sel.

Behaviour:
Reset
- i_rst low asynchronously clears all 32 registers to 0, independent of i_clk.
- While i_rst is low, all outputs read 0 and writes are ignored.
- Deassertion (i_rst rising) takes effect at the next rising edge of i_clk; no register changes on the deassertion itself.

Write
- On rising i_clk with i_rst high and i_wr_en high: reg[i_rd_sel] <= i_wr_data.
- With i_wr_en low, no register changes.
- i_rd_sel == 0: the write is discarded; reg[0] always reads 0.
- A register written once holds its value until overwritten or reset.

Read
- All three read ports are purely combinational from the select inputs (zero-cycle latency).
- Any select change is reflected at the output in the same cycle.
- Select 0 always returns 0 on every port.
- Write-through bypass on o_rs_data and o_rt_data: if i_wr_en is high, i_rd_sel != 0, and the port's select equals i_rd_sel, the port returns i_wr_data in the same cycle, before the clock edge. This resolves the WB/ID hazard in the same cycle.
- o_dbg_data has no bypass; it returns stored contents only.

Simultaneous events and boundaries
- rs and rt selects may be equal; both ports return the same value.
- Writes to register 31 are permitted with no special meaning.
- Selects are full-width; there is no out-of-range case.
- Back-to-back writes to the same register in consecutive cycles: the last write wins.

Test Plan:
- Reset clears: hold i_rst low, write 32'hDEADBEEF to r5 with i_wr_en=1 and clock 3 cycles -> o_rs_data (sel 5) = 0. Release i_rst, read all 32 via o_dbg_data -> all 0.
- Zero register: write 32'hFFFFFFFF to r0 with i_wr_en=1, one edge -> o_rs_data, o_rt_data and o_dbg_data with sel 0 all read 32'h00000000.
- Write/readback: write 32'hFFFFFFFF to r1, then drop i_wr_en, set i_rs_sel=1 -> o_rs_data = 32'hFFFFFFFF.
- Dual write/read: write 32'h0123ABCD to r1, then 32'h4567EF01 to r2; set rs=1, rt=2 -> o_rs_data = 32'h0123ABCD, o_rt_data = 32'h4567EF01.
- Bypass: rs=rt=7, r7=0. Drive i_rd_sel=7, i_wr_en=1, i_wr_data=32'h0000_1234 before the edge -> both read ports show 32'h00001234 pre-edge; o_dbg_data (sel 7) shows 0 pre-edge and 32'h00001234 post-edge.
- Write-enable gating and async reset mid-run: i_wr_en=0 with data 32'hAAAA5555 to r3 -> r3 unchanged. Then pulse i_rst low between clock edges -> r1, r2 and all other registers read 0 immediately.
